// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types, widths and bypass mux for regfile_ctrl
package regfile_ctrl_pkg;

   localparam int p_WORD_LEN      = 16;
   localparam int p_REG_ADDR_LEN  = 3;
   localparam int p_REG_FILE_SIZE = 8;

   typedef logic [p_WORD_LEN-1:0]     word_t;
   typedef logic [p_REG_ADDR_LEN-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      DBG_ACK
   } state_t;

   // r0 is forced to zero here so a corrupted file can never leak through.
   function automatic word_t bypass_mux(
      input logic      wb_en,
      input reg_addr_t wb_tgt,
      input word_t     wb_data,
      input reg_addr_t src,
      input word_t     rf_data
   );
      word_t data;
      if (src == '0) begin
         data = '0;
      end else if (wb_en && (wb_tgt == src)) begin
         data = wb_data;
      end else begin
         data = rf_data;
      end
      return data;
   endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// rtl/regfile_ctrl_if.sv - pipeline, debug host and register file signals of regfile_ctrl
interface regfile_ctrl_if;
   import regfile_ctrl_pkg::*;

   reg_addr_t i_id_src1;
   reg_addr_t i_id_src2;
   logic      i_id_rd_en;
   word_t     o_id_src1_data;
   word_t     o_id_src2_data;

   logic      i_wb_en;
   reg_addr_t i_wb_tgt;
   word_t     i_wb_data;
   logic      o_stall;

   logic      i_dbg_req;
   logic      i_dbg_we;
   reg_addr_t i_dbg_addr;
   word_t     i_dbg_wdata;
   logic      o_dbg_ack;
   word_t     o_dbg_rdata;

   reg_addr_t o_rf_src1;
   reg_addr_t o_rf_src2;
   word_t     i_rf_src1_data;
   word_t     i_rf_src2_data;
   reg_addr_t o_rf_tgt;
   word_t     o_rf_tgt_data;
   logic      o_rf_wr_en;

   modport slave (
      input  i_id_src1, i_id_src2, i_id_rd_en,
      input  i_wb_en, i_wb_tgt, i_wb_data,
      input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  i_rf_src1_data, i_rf_src2_data,
      output o_id_src1_data, o_id_src2_data, o_stall,
      output o_dbg_ack, o_dbg_rdata,
      output o_rf_src1, o_rf_src2, o_rf_tgt, o_rf_tgt_data, o_rf_wr_en
   );

   modport master (
      output i_id_src1, i_id_src2, i_id_rd_en,
      output i_wb_en, i_wb_tgt, i_wb_data,
      output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output i_rf_src1_data, i_rf_src2_data,
      input  o_id_src1_data, o_id_src2_data, o_stall,
      input  o_dbg_ack, o_dbg_rdata,
      input  o_rf_src1, o_rf_src2, o_rf_tgt, o_rf_tgt_data, o_rf_wr_en
   );

endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - writeback-to-read bypass for one register file read port
module regfile_bypass
   import regfile_ctrl_pkg::*;
(
   input  logic      i_wb_en,
   input  reg_addr_t i_wb_tgt,
   input  word_t     i_wb_data,
   input  reg_addr_t i_src,
   input  word_t     i_rf_data,
   output word_t     o_data
);

   assign o_data = bypass_mux(i_wb_en, i_wb_tgt, i_wb_data, i_src, i_rf_data);

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register file port arbiter: post-reset clear, wb bypass, debug host access
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int p_DBG_MAX_WAIT = 4
) (
   input logic           i_clk,
   input logic           i_rst,
   regfile_ctrl_if.slave bus
);

   localparam int                WAIT_W   = $clog2(p_DBG_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(p_DBG_MAX_WAIT);
   localparam reg_addr_t         LAST_IDX = reg_addr_t'(p_REG_FILE_SIZE - 1);

   state_t            state_q,     state_d;
   reg_addr_t         clr_idx_q,   clr_idx_d;
   logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
   word_t             dbg_rdata_q, dbg_rdata_d;

   logic      dbg_rd_grant;
   logic      dbg_wr_grant;
   reg_addr_t rf_src1;
   word_t     src1_byp;
   word_t     src2_byp;

   // Read-port steering is kept outside the FSM process so the bypass result can feed the capture.
   assign dbg_rd_grant  = (state_q == IDLE) && bus.i_dbg_req && !bus.i_dbg_we && !bus.i_id_rd_en;
   assign dbg_wr_grant  = (state_q == IDLE) && bus.i_dbg_req && bus.i_dbg_we && !bus.i_wb_en;
   assign rf_src1       = dbg_rd_grant ? bus.i_dbg_addr : bus.i_id_src1;
   assign bus.o_rf_src1 = rf_src1;
   assign bus.o_rf_src2 = bus.i_id_src2;

   regfile_bypass u_bypass1 (
      .i_wb_en   (bus.i_wb_en),
      .i_wb_tgt  (bus.i_wb_tgt),
      .i_wb_data (bus.i_wb_data),
      .i_src     (rf_src1),
      .i_rf_data (bus.i_rf_src1_data),
      .o_data    (src1_byp)
   );

   regfile_bypass u_bypass2 (
      .i_wb_en   (bus.i_wb_en),
      .i_wb_tgt  (bus.i_wb_tgt),
      .i_wb_data (bus.i_wb_data),
      .i_src     (bus.i_id_src2),
      .i_rf_data (bus.i_rf_src2_data),
      .o_data    (src2_byp)
   );

   assign bus.o_id_src1_data = src1_byp;
   assign bus.o_id_src2_data = src2_byp;
   assign bus.o_dbg_ack      = (state_q == DBG_ACK);
   assign bus.o_dbg_rdata    = dbg_rdata_q;

   always_comb begin
      state_d           = state_q;
      clr_idx_d         = clr_idx_q;
      wait_cnt_d        = wait_cnt_q;
      dbg_rdata_d       = dbg_rdata_q;
      bus.o_rf_wr_en    = 1'b0;
      bus.o_rf_tgt      = '0;
      bus.o_rf_tgt_data = '0;
      bus.o_stall       = 1'b0;

      case (state_q)
         CLEAR: begin
            bus.o_rf_wr_en = 1'b1;
            bus.o_rf_tgt   = clr_idx_q;
            bus.o_stall    = 1'b1;
            if (clr_idx_q == LAST_IDX) begin
               state_d   = IDLE;
               clr_idx_d = reg_addr_t'(1);
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end

         IDLE: begin
            if (bus.i_wb_en) begin
               bus.o_rf_wr_en    = (bus.i_wb_tgt != '0);
               bus.o_rf_tgt      = bus.i_wb_tgt;
               bus.o_rf_tgt_data = bus.i_wb_data;
            end else if (dbg_wr_grant) begin
               bus.o_rf_wr_en    = (bus.i_dbg_addr != '0);
               bus.o_rf_tgt      = bus.i_dbg_addr;
               bus.o_rf_tgt_data = bus.i_dbg_wdata;
            end

            if (dbg_rd_grant) begin
               dbg_rdata_d = src1_byp;
            end

            bus.o_stall = bus.i_dbg_req && (wait_cnt_q == WAIT_MAX);

            if (dbg_rd_grant || dbg_wr_grant) begin
               state_d    = DBG_ACK;
               wait_cnt_d = '0;
            end else if (bus.i_dbg_req) begin
               if (wait_cnt_q != WAIT_MAX) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               wait_cnt_d = '0;
            end
         end

         DBG_ACK: begin
            if (bus.i_wb_en) begin
               bus.o_rf_wr_en    = (bus.i_wb_tgt != '0);
               bus.o_rf_tgt      = bus.i_wb_tgt;
               bus.o_rf_tgt_data = bus.i_wb_data;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= CLEAR;
         clr_idx_q   <= reg_addr_t'(1);
         wait_cnt_q  <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_idx_q   <= clr_idx_d;
         wait_cnt_q  <= wait_cnt_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule
